// File: rtl/conv_host_pkg.sv
// rtl/conv_host_pkg.sv - shared constants and state type for the convolution host responder
package conv_host_pkg;

  localparam int DW        = 20;
  localparam int IMG_DEPTH = 4096;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_host_mem.sv
// rtl/conv_host_mem.sv - 20-bit memory, one synchronous write port, two combinational read ports
module conv_host_mem
  import conv_host_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  // Contents are deliberately never reset so a mid-run reset keeps the image.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/conv_host_responder.sv
// rtl/conv_host_responder.sv - memory-side responder: image/L0/L1 memories, ready/busy FSM, status
module conv_host_responder
  import conv_host_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000,
  parameter int L0_DEPTH    = 4096,
  parameter int L1_DEPTH    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_we,
  input  logic [11:0] load_addr,
  input  logic [19:0] load_data,
  input  logic        start,
  output logic        ready,
  input  logic        busy,
  input  logic [11:0] iaddr,
  output logic [19:0] idata,
  input  logic        cwr,
  input  logic [11:0] caddr_wr,
  input  logic [19:0] cdata_wr,
  input  logic        crd,
  input  logic [11:0] caddr_rd,
  output logic [19:0] cdata_rd,
  input  logic [2:0]  csel,
  input  logic [2:0]  rb_sel,
  input  logic [11:0] rb_addr,
  output logic [19:0] rb_data,
  output logic        done,
  output logic        timeout,
  output logic        err,
  output logic [19:0] run_cycles,
  output logic [12:0] wr_count0,
  output logic [10:0] wr_count1
);

  localparam int L0_AW = $clog2(L0_DEPTH);
  localparam int L1_AW = $clog2(L1_DEPTH);

  state_t      state;
  logic [31:0] tcnt;
  logic        active;
  logic        timed_out;
  logic        l0_sel, l1_sel;
  logic        l1_wr_ok, l1_rd_ok, rb_l1_ok;
  logic        l0_we, l1_we, bad_wr, bad_rd;
  logic [DW-1:0] l0_rd_a, l0_rd_b, l1_rd_a, l1_rd_b;

  assign active    = (state == READY) || (state == RUN);
  assign timed_out = (tcnt == 32'(TIMEOUT_CYC - 1));

  assign l0_sel   = (csel == CSEL_L0);
  assign l1_sel   = (csel == CSEL_L1);
  assign l1_wr_ok = ((caddr_wr >> L1_AW) == 12'd0);
  assign l1_rd_ok = ((caddr_rd >> L1_AW) == 12'd0);
  assign rb_l1_ok = ((rb_addr  >> L1_AW) == 12'd0);

  assign l0_we  = active && cwr && l0_sel;
  assign l1_we  = active && cwr && l1_sel && l1_wr_ok;
  assign bad_wr = active && cwr && !(l0_sel || (l1_sel && l1_wr_ok));
  assign bad_rd = active && crd && !(l0_sel || l1_sel);

  conv_host_mem #(.DEPTH(IMG_DEPTH)) u_img (
    .clk     (clk),
    .we      (load_we && (state == IDLE)),
    .waddr   (load_addr),
    .wdata   (load_data),
    .raddr_a (iaddr),
    .rdata_a (idata),
    .raddr_b (load_addr),
    .rdata_b ()
  );

  conv_host_mem #(.DEPTH(L0_DEPTH)) u_l0 (
    .clk     (clk),
    .we      (l0_we),
    .waddr   (caddr_wr[L0_AW-1:0]),
    .wdata   (cdata_wr),
    .raddr_a (caddr_rd[L0_AW-1:0]),
    .rdata_a (l0_rd_a),
    .raddr_b (rb_addr[L0_AW-1:0]),
    .rdata_b (l0_rd_b)
  );

  conv_host_mem #(.DEPTH(L1_DEPTH)) u_l1 (
    .clk     (clk),
    .we      (l1_we),
    .waddr   (caddr_wr[L1_AW-1:0]),
    .wdata   (cdata_wr),
    .raddr_a (caddr_rd[L1_AW-1:0]),
    .rdata_a (l1_rd_a),
    .raddr_b (rb_addr[L1_AW-1:0]),
    .rdata_b (l1_rd_b)
  );

  // Reads are pre-edge, so a same-cycle write to the read address shows old data.
  always_comb begin
    cdata_rd = '0;
    if (crd && l0_sel)                cdata_rd = l0_rd_a;
    else if (crd && l1_sel && l1_rd_ok) cdata_rd = l1_rd_a;
  end

  always_comb begin
    rb_data = '0;
    if (rb_sel == CSEL_L0)                 rb_data = l0_rd_b;
    else if (rb_sel == CSEL_L1 && rb_l1_ok) rb_data = l1_rd_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
      run_cycles <= '0;
      wr_count0  <= '0;
      wr_count1  <= '0;
      tcnt       <= '0;
    end else begin
      done <= 1'b0;
      if (bad_wr || bad_rd) err <= 1'b1;
      if (l0_we) wr_count0 <= wr_count0 + 13'd1;
      if (l1_we) wr_count1 <= wr_count1 + 11'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= READY;
            ready      <= 1'b1;
            tcnt       <= '0;
            timeout    <= 1'b0;
            err        <= 1'b0;
            run_cycles <= '0;
            wr_count0  <= '0;
            wr_count1  <= '0;
          end
        end
        READY: begin
          if (timed_out) begin
            timeout <= 1'b1;
            ready   <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + 32'd1;
            if (busy) begin
              ready <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (run_cycles != 20'hFFFFF) run_cycles <= run_cycles + 20'd1;
          if (timed_out) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + 32'd1;
            if (!busy) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_host_responder.sv
// tb/tb_conv_host_responder.sv - randomized self-checking bench against a behavioural memory/handshake model
module tb_conv_host_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_we = 1'b0;
  logic [11:0] load_addr = '0;
  logic [19:0] load_data = '0;
  logic        start = 1'b0;
  logic        ready;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [19:0] idata;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [19:0] cdata_wr = '0;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic [19:0] cdata_rd;
  logic [2:0]  csel = '0;
  logic [2:0]  rb_sel = '0;
  logic [11:0] rb_addr = '0;
  logic [19:0] rb_data;
  logic        done;
  logic        timeout;
  logic        err;
  logic [19:0] run_cycles;
  logic [12:0] wr_count0;
  logic [10:0] wr_count1;

  always #5 clk = ~clk;

  conv_host_responder #(.TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
    .done(done), .timeout(timeout), .err(err), .run_cycles(run_cycles),
    .wr_count0(wr_count0), .wr_count1(wr_count1)
  );

  int checks = 0;
  int errors = 0;

  logic [19:0] img_m [4096];
  logic [19:0] l0_m [4096];
  logic [19:0] l1_m [1024];
  bit          l0_v [4096];
  bit          l1_v [1024];
  int          l0_q [$];
  int          l1_q [$];
  int          wc0, wc1;
  bit          err_e;
  logic [2:0]  bad_codes [6] = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    wc0 = 0; wc1 = 0; err_e = 1'b0;
    check("ready_after_start", ready, 1);
    check("err_cleared", err, 0);
    check("timeout_cleared", timeout, 0);
    check("run_cycles_cleared", run_cycles, 0);
    check("wr_count0_cleared", wr_count0, 0);
    check("wr_count1_cleared", wr_count1, 0);
  endtask

  // kind 0: L0 write (+read), 1: L1 write (+read), 2: invalid-csel write, 3: invalid-csel read
  task automatic access(input int kind, input logic [11:0] wa, input logic [19:0] wd,
                        input logic [11:0] ra, input logic [2:0] bad);
    logic [19:0] exp_rd;
    exp_rd = '0;
    caddr_wr = wa; cdata_wr = wd; caddr_rd = ra; cwr = 1'b0; crd = 1'b0;
    load_we = 1'b1; load_addr = wa; load_data = ~wd;
    case (kind)
      0: begin
        csel = 3'b001; cwr = 1'b1; crd = l0_v[ra];
        if (l0_v[ra]) exp_rd = l0_m[ra];
      end
      1: begin
        csel = 3'b011; cwr = 1'b1;
        crd = (ra[11:10] == 2'b00) && l1_v[ra[9:0]];
        if (crd) exp_rd = l1_m[ra[9:0]];
      end
      2: begin csel = bad; cwr = 1'b1; end
      default: begin csel = bad; crd = 1'b1; end
    endcase
    #1;
    check("cdata_rd", cdata_rd, exp_rd);
    step();
    case (kind)
      0: begin
        l0_m[wa] = wd; l0_v[wa] = 1'b1; l0_q.push_back(int'(wa)); wc0++;
      end
      1: begin
        if (wa[11:10] == 2'b00) begin
          l1_m[wa[9:0]] = wd; l1_v[wa[9:0]] = 1'b1; l1_q.push_back(int'(wa[9:0])); wc1++;
        end else err_e = 1'b1;
      end
      default: err_e = 1'b1;
    endcase
    cwr = 1'b0; crd = 1'b0; load_we = 1'b0;
    check("err_track", err, err_e);
  endtask

  task automatic random_access();
    int kind;
    logic [11:0] wa, ra;
    logic [19:0] wd;
    kind = $urandom_range(0, 9);
    wd = 20'($urandom);
    if (kind < 5) begin
      wa = 12'($urandom_range(0, 4095));
      ra = ($urandom_range(0, 1) == 1 && l0_q.size() > 0) ? 12'(l0_q[$urandom_range(0, l0_q.size()-1)]) : wa;
      access(0, wa, wd, ra, 3'b000);
    end else if (kind < 8) begin
      wa = ($urandom_range(0, 3) == 0) ? {2'($urandom_range(1, 3)), 10'($urandom)} : {2'b00, 10'($urandom)};
      ra = ($urandom_range(0, 1) == 1 && l1_q.size() > 0) ? 12'(l1_q[$urandom_range(0, l1_q.size()-1)]) : wa;
      access(1, wa, wd, ra, 3'b000);
    end else begin
      access(kind == 8 ? 2 : 3, 12'($urandom), wd, 12'($urandom), bad_codes[$urandom_range(0, 5)]);
    end
  endtask

  task automatic run(input int r, input int d, input bit directed);
    do_start();
    repeat (d) begin
      step();
      check("ready_hold", ready, 1);
    end
    busy = 1'b1;
    step();
    check("ready_release", ready, 0);
    for (int i = 0; i < r - 1; i++) begin
      if (directed && i == 0)      access(0, 12'd4095, 20'h12345, 12'd0, 3'b000);
      else if (directed && i == 1) access(0, 12'd4095, 20'hABCDE, 12'd4095, 3'b000);
      else if (directed && i == 2) access(1, 12'h400, 20'h55555, 12'h000, 3'b000);
      else if (directed && i == 3) access(3, 12'h000, 20'h0, 12'h010, 3'b010);
      else random_access();
    end
    busy = 1'b0;
    step();
    check("done_pulse", done, 1);
    check("run_cycles", run_cycles, r);
    check("wr_count0", wr_count0, wc0);
    check("wr_count1", wr_count1, wc1);
    check("err_end", err, err_e);
    check("timeout_none", timeout, 0);
    step();
    check("done_one_cycle", done, 0);
    check("ready_idle", ready, 0);
  endtask

  task automatic check_image(input int n);
    for (int i = 0; i < n; i++) begin
      iaddr = 12'($urandom_range(0, 4095));
      #1;
      check("idata", idata, img_m[iaddr]);
    end
  endtask

  initial begin
    step();
    step();
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err", err, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_wr_count0", wr_count0, 0);
    check("rst_wr_count1", wr_count1, 0);
    reset = 1'b0;
    step();

    for (int a = 0; a < 4096; a++) begin
      load_we = 1'b1; load_addr = 12'(a); load_data = 20'(a + 5);
      img_m[a] = 20'(a + 5);
      step();
    end
    load_we = 1'b0;
    iaddr = 12'h0A3;
    #1;
    check("idata_0A3", idata, 20'h000A8);
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = 12'($urandom_range(0, 4095)); load_data = 20'($urandom);
      img_m[load_addr] = load_data;
      step();
    end
    load_we = 1'b0;
    check_image(16);

    // start at edge 1, busy seen at edge 3, ten RUN cycles
    run(10, 1, 1'b1);
    rb_sel = 3'b001; rb_addr = 12'd4095;
    #1;
    check("rb_l0_4095", rb_data, 20'hABCDE);

    for (int k = 0; k < 6; k++) run($urandom_range(2, 30), $urandom_range(0, 3), 1'b0);

    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        rb_sel = 3'b001; rb_addr = 12'(l0_q[$urandom_range(0, l0_q.size()-1)]);
        #1; check("rb_l0", rb_data, l0_m[rb_addr]);
      end else if (sel == 1 && l1_q.size() > 0) begin
        rb_sel = 3'b011; rb_addr = {2'b00, 10'(l1_q[$urandom_range(0, l1_q.size()-1)])};
        #1; check("rb_l1", rb_data, l1_m[rb_addr[9:0]]);
      end else begin
        rb_sel = bad_codes[$urandom_range(0, 5)]; rb_addr = 12'(l0_q[0]);
        #1; check("rb_invalid", rb_data, 0);
      end
    end
    check_image(16);

    busy = 1'b1;
    repeat (4) step();
    check("busy_idle_ready", ready, 0);
    check("busy_idle_err", err, err_e);
    busy = 1'b0;
    step();

    do_start();
    for (int i = 1; i < 50; i++) begin
      step();
      check("timeout_wait_done", done, 0);
    end
    step();
    check("timeout_done", done, 1);
    check("timeout_flag", timeout, 1);
    step();
    check("timeout_idle_ready", ready, 0);
    check("timeout_sticky", timeout, 1);

    do_start();
    busy = 1'b1;
    step();
    step();
    check("rst_mid_in_run", ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_ready", ready, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_run_cycles", run_cycles, 0);
    busy = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("rst_mid_idle", ready, 0);
    check_image(16);
    do_start();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
